router_pkt_tx: RTL

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_pkt_tx_if.sv | 42 ++++
 rtl/router_tx_buf.sv | 25 ++
 rtl/router_pkt_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter: FSM states,
// header field widths and request legality constants.
package router_pkg;

    localparam int LEN_W   = 6;
    localparam int ADDR_W  = 2;
    localparam int MAX_LEN = 63;

    localparam logic [ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_DONE
    } state_t;

    // Header byte layout: length in the upper six bits, port in the lower two.
    function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                               input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, payload-source and router-side signals of router_pkt_tx.
// corrupt_parity exists only when ROUTER_TX_PARITY_INJ_EN is defined.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [7:0]        pl_data;
    logic              pl_valid;
    logic              pl_ready;
    logic              busy;
    logic [7:0]        data_out;
    logic              pkt_valid;
    logic              tx_active;
    logic              done;
    logic              err;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic              corrupt_parity;

    modport slave (
        input  start, addr, len, pl_data, pl_valid, busy, corrupt_parity,
        output pl_ready, data_out, pkt_valid, tx_active, done, err
    );

    modport master (
        output start, addr, len, pl_data, pl_valid, busy, corrupt_parity,
        input  pl_ready, data_out, pkt_valid, tx_active, done, err
    );
`else
    modport slave (
        input  start, addr, len, pl_data, pl_valid, busy,
        output pl_ready, data_out, pkt_valid, tx_active, done, err
    );

    modport master (
        output start, addr, len, pl_data, pl_valid, busy,
        input  pl_ready, data_out, pkt_valid, tx_active, done, err
    );
`endif

endinterface

// File: rtl/router_tx_buf.sv
// Payload byte buffer: synchronous write, combinational read, no reset
// (contents are always written before they are read).
module router_tx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and an
// XOR parity byte to the router. ROUTER_TX_PARITY_INJ_EN adds parity corruption.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int BUF_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    router_pkt_tx_if.slave  bus
);

    localparam int AW = $clog2(BUF_DEPTH);

    state_t            state_reg,     state_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [LEN_W-1:0]  len_reg,       len_next;
    logic [LEN_W-1:0]  wr_cnt_reg,    wr_cnt_next;
    logic [LEN_W-1:0]  rd_ptr_reg,    rd_ptr_next;
    logic [7:0]        parity_reg,    parity_next;
    logic [7:0]        data_out_reg,  data_out_next;
    logic              pkt_valid_reg, pkt_valid_next;
    logic              err_reg,       err_next;
    logic              inj_reg,       inj_next;

    logic              inj_in;
    logic              legal_req;
    logic              wr_en;
    logic [7:0]        rd_data;

`ifdef ROUTER_TX_PARITY_INJ_EN
    assign inj_in = bus.corrupt_parity;
`else
    assign inj_in = 1'b0;
`endif

    assign legal_req = (bus.addr != ILLEGAL_ADDR) && (bus.len != '0);

    router_tx_buf #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (AW'(wr_cnt_reg)),
        .wr_data (bus.pl_data),
        .rd_addr (AW'(rd_ptr_reg)),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            len_reg       <= '0;
            wr_cnt_reg    <= '0;
            rd_ptr_reg    <= '0;
            parity_reg    <= '0;
            data_out_reg  <= '0;
            pkt_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            inj_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            wr_cnt_reg    <= wr_cnt_next;
            rd_ptr_reg    <= rd_ptr_next;
            parity_reg    <= parity_next;
            data_out_reg  <= data_out_next;
            pkt_valid_reg <= pkt_valid_next;
            err_reg       <= err_next;
            inj_reg       <= inj_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        wr_cnt_next    = wr_cnt_reg;
        rd_ptr_next    = rd_ptr_reg;
        parity_next    = parity_reg;
        data_out_next  = data_out_reg;
        pkt_valid_next = pkt_valid_reg;
        err_next       = 1'b0;
        inj_next       = inj_reg;
        wr_en          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                data_out_next  = '0;
                pkt_valid_next = 1'b0;
                if (bus.start) begin
                    if (legal_req) begin
                        addr_next   = bus.addr;
                        len_next    = bus.len;
                        wr_cnt_next = '0;
                        rd_ptr_next = '0;
                        parity_next = '0;
                        inj_next    = inj_in;
                        state_next  = ST_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (bus.pl_valid) begin
                    wr_en       = 1'b1;
                    wr_cnt_next = LEN_W'(wr_cnt_reg + 1'b1);
                    // Header goes out the cycle right after the last payload byte lands.
                    if (LEN_W'(wr_cnt_reg + 1'b1) == len_reg) begin
                        data_out_next  = make_header(len_reg, addr_reg);
                        pkt_valid_next = 1'b1;
                        state_next     = ST_HEADER;
                    end
                end
            end

            ST_HEADER: begin
                if (!bus.busy) begin
                    parity_next   = parity_reg ^ data_out_reg;
                    data_out_next = rd_data;
                    rd_ptr_next   = LEN_W'(rd_ptr_reg + 1'b1);
                    state_next    = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    parity_next = parity_reg ^ data_out_reg;
                    // rd_ptr counts bytes already presented; equal to len means the last one just left.
                    if (rd_ptr_reg == len_reg) begin
                        data_out_next  = parity_next ^ {7'b0, inj_reg};
                        pkt_valid_next = 1'b0;
                        state_next     = ST_PARITY;
                    end else begin
                        data_out_next = rd_data;
                        rd_ptr_next   = LEN_W'(rd_ptr_reg + 1'b1);
                    end
                end
            end

            ST_PARITY: begin
                if (!bus.busy) begin
                    data_out_next  = '0;
                    pkt_valid_next = 1'b0;
                    state_next     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out  = data_out_reg;
    assign bus.pkt_valid = pkt_valid_reg;
    assign bus.err       = err_reg;
    assign bus.pl_ready  = (state_reg == ST_LOAD);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.tx_active = (state_reg == ST_LOAD)    || (state_reg == ST_HEADER) ||
                           (state_reg == ST_PAYLOAD) || (state_reg == ST_PARITY);

endmodule
